// File: rtl/ssemi_cic_decimator_mc_pkg.sv
// Shared types and constants for the multi-channel CIC decimator.
package ssemi_cic_decimator_mc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam int MIN_DEC_LOG2     = 5;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_CIC_STAGES   = 4;
    localparam int DEF_IN_W         = 16;
    localparam int DEF_OUT_W        = 24;
    localparam int DEF_MAX_DEC_LOG2 = 9;
    localparam int DEF_DEC_LOG2     = 6;

    // Accumulator width that holds the full CIC gain at the largest decimation.
    function automatic int calc_acc_w(input int in_w, input int stages, input int max_dec_log2);
        return in_w + stages * max_dec_log2;
    endfunction

endpackage

// File: rtl/ssemi_cic_integrator_bank.sv
// NUM_CH x CIC_STAGES integrator array; every stage of every channel advances
// together on each accepted frame, wrapping modulo 2^ACC_W.
module ssemi_cic_integrator_bank #(
    parameter int NUM_CH     = 4,
    parameter int CIC_STAGES = 4,
    parameter int IN_W       = 16,
    parameter int ACC_W      = 52
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [NUM_CH*IN_W-1:0]  data,
    output logic [NUM_CH*ACC_W-1:0] last_next
);

    logic signed [ACC_W-1:0] integ    [NUM_CH][CIC_STAGES];
    logic signed [ACC_W-1:0] stage_in [NUM_CH][CIC_STAGES];

    // Stage inputs: sign-extended sample into stage 0, previous stage value into the rest;
    // last_next is what the final stage will hold after this accept.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            stage_in[ch][0] = {{(ACC_W-IN_W){data[ch*IN_W+IN_W-1]}}, data[ch*IN_W +: IN_W]};
            for (int s = 1; s < CIC_STAGES; s++) begin
                stage_in[ch][s] = integ[ch][s-1];
            end
            last_next[ch*ACC_W +: ACC_W] = integ[ch][CIC_STAGES-1] + stage_in[ch][CIC_STAGES-1];
        end
    end

    // Integrator state: cleared on reset or reconfiguration, accumulates on accept.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int s = 0; s < CIC_STAGES; s++) begin
                    integ[ch][s] <= '0;
                end
            end
        end else if (en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int s = 0; s < CIC_STAGES; s++) begin
                    integ[ch][s] <= integ[ch][s] + stage_in[ch][s];
                end
            end
        end
    end

endmodule

// File: rtl/ssemi_cic_decimator_mc.sv
// Multi-channel CIC decimator: shared integrator bank, time-multiplexed comb
// chain and gain-normalising shifter, channel-serialised valid/ready output.
module ssemi_cic_decimator_mc
    import ssemi_cic_decimator_mc_pkg::*;
#(
    parameter int NUM_CH           = DEF_NUM_CH,
    parameter int CIC_STAGES       = DEF_CIC_STAGES,
    parameter int IN_W             = DEF_IN_W,
    parameter int OUT_W            = DEF_OUT_W,
    parameter int MAX_DEC_LOG2     = DEF_MAX_DEC_LOG2,
    parameter int DEFAULT_DEC_LOG2 = DEF_DEC_LOG2
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_enable,
    input  logic                                         i_valid,
    output logic                                         o_ready,
    input  logic [NUM_CH*IN_W-1:0]                       i_data,
    output logic                                         o_valid,
    input  logic                                         i_ready,
    output logic [OUT_W-1:0]                             o_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_ch,
    input  logic                                         i_cfg_load,
    input  logic [3:0]                                   i_dec_log2,
    input  logic                                         i_clr_status,
    output logic [3:0]                                   o_dec_log2,
    output logic                                         o_cfg_err,
    output logic                                         o_overrun,
    output logic                                         o_busy
);

    localparam int ACC_W  = calc_acc_w(IN_W, CIC_STAGES, MAX_DEC_LOG2);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAIN_W = OUT_W - IN_W;

    // Remove the CIC gain (2^(N*dec_log2)) while keeping GAIN_W bits of headroom growth.
    function automatic logic signed [OUT_W-1:0] normalise(input logic signed [ACC_W-1:0] v,
                                                          input logic [3:0] dl2);
        logic [7:0]              sh;
        logic signed [ACC_W-1:0] shifted;
        sh      = 8'(CIC_STAGES * int'(dl2) - GAIN_W);
        shifted = v >>> sh;
        return shifted[OUT_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q;
    logic [3:0]              dec_q;
    logic                    cfg_err_q;
    logic                    overrun_q;
    logic [MAX_DEC_LOG2-1:0] cnt_q;
    logic [MAX_DEC_LOG2-1:0] term_cnt;

    logic signed [ACC_W-1:0] snap     [NUM_CH];
    logic signed [ACC_W-1:0] comb_dly [NUM_CH][CIC_STAGES];
    logic signed [ACC_W-1:0] comb_tap [CIC_STAGES];
    logic signed [ACC_W-1:0] comb_acc;
    logic [NUM_CH*ACC_W-1:0] last_next;

    logic is_idle, load_idle, load_ok, accept, cnt_last, term, clr_dp, handshake, last_ch;

    assign is_idle   = (state_q == ST_IDLE);
    assign load_idle = i_cfg_load && is_idle;
    assign load_ok   = (i_dec_log2 >= 4'(MIN_DEC_LOG2)) && (i_dec_log2 <= 4'(MAX_DEC_LOG2));
    assign accept    = i_valid && o_ready && !load_idle;
    assign term_cnt  = MAX_DEC_LOG2'((32'd1 << dec_q) - 32'd1);
    assign cnt_last  = (cnt_q == term_cnt);
    assign term      = accept && cnt_last;
    assign clr_dp    = load_idle && load_ok;
    assign handshake = o_valid && i_ready;
    assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));

    assign o_ready    = i_enable && !cfg_err_q;
    assign o_valid    = (state_q == ST_EMIT);
    assign o_busy     = (state_q == ST_EMIT);
    assign o_ch       = ch_q;
    assign o_dec_log2 = dec_q;
    assign o_cfg_err  = cfg_err_q;
    assign o_overrun  = overrun_q;
    assign o_data     = o_valid ? normalise(comb_acc, dec_q) : '0;

    ssemi_cic_integrator_bank #(
        .NUM_CH     (NUM_CH),
        .CIC_STAGES (CIC_STAGES),
        .IN_W       (IN_W),
        .ACC_W      (ACC_W)
    ) u_integ (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (clr_dp),
        .en        (accept),
        .data      (i_data),
        .last_next (last_next)
    );

    // Comb chain for the channel currently being emitted; comb_tap holds each stage input
    // so it can become that stage's delay value once the word is taken.
    always_comb begin
        comb_acc = snap[ch_q];
        for (int s = 0; s < CIC_STAGES; s++) begin
            comb_tap[s] = comb_acc;
            comb_acc    = comb_acc - comb_dly[ch_q][s];
        end
    end

    // Next-state logic: a terminal accept starts a frame, the last channel handshake ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (term) state_d = ST_EMIT;
            ST_EMIT: if (handshake && last_ch) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Output channel index advances on each taken word and returns to 0 at frame end.
    always_ff @(posedge i_clk) begin
        if (i_rst)          ch_q <= '0;
        else if (handshake) ch_q <= last_ch ? '0 : ch_q + CH_W'(1);
    end

    // Decimation phase counter; a legal reconfiguration restarts it.
    always_ff @(posedge i_clk) begin
        if (i_rst || clr_dp) cnt_q <= '0;
        else if (accept)     cnt_q <= cnt_last ? '0 : cnt_q + MAX_DEC_LOG2'(1);
    end

    // Configuration: only honoured while idle; an illegal value halts input until fixed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dec_q     <= 4'(DEFAULT_DEC_LOG2);
            cfg_err_q <= 1'b0;
        end else if (load_idle) begin
            if (load_ok) begin
                dec_q     <= i_dec_log2;
                cfg_err_q <= 1'b0;
            end else begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    // Sticky overrun: a new event beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst)                        overrun_q <= 1'b0;
        else if (term && !is_idle)        overrun_q <= 1'b1;
        else if (i_clr_status)            overrun_q <= 1'b0;
    end

    // Snapshot of the final integrator stage (including the terminal sample) for each channel.
    always_ff @(posedge i_clk) begin
        if (term && is_idle) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                snap[ch] <= last_next[ch*ACC_W +: ACC_W];
            end
        end
    end

    // Comb delay registers: committed per channel only when its word is accepted downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst || clr_dp) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int s = 0; s < CIC_STAGES; s++) begin
                    comb_dly[ch][s] <= '0;
                end
            end
        end else if (handshake) begin
            for (int s = 0; s < CIC_STAGES; s++) begin
                comb_dly[ch_q][s] <= comb_tap[s];
            end
        end
    end

endmodule

// File: tb/tb_ssemi_cic_decimator_mc.sv
// Directed testbench for ssemi_cic_decimator_mc (4 channels, 4 stages, 16 -> 24 bit).
module tb_ssemi_cic_decimator_mc;

    logic               clk = 1'b0;
    logic               i_rst, i_enable, i_valid, i_ready, i_cfg_load, i_clr_status;
    logic [63:0]        i_data;
    logic [3:0]         i_dec_log2;
    logic               o_ready, o_valid, o_cfg_err, o_overrun, o_busy;
    logic signed [23:0] o_data;
    logic [1:0]         o_ch;
    logic [3:0]         o_dec_log2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssemi_cic_decimator_mc dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_ch         (o_ch),
        .i_cfg_load   (i_cfg_load),
        .i_dec_log2   (i_dec_log2),
        .i_clr_status (i_clr_status),
        .o_dec_log2   (o_dec_log2),
        .o_cfg_err    (o_cfg_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic signed [15:0] c, input logic signed [15:0] d);
        i_data = {d, c, b, a};
    endtask

    task automatic load_dec(input logic [3:0] v);
        i_cfg_load = 1'b1;
        i_dec_log2 = v;
        step();
        i_cfg_load = 1'b0;
    endtask

    // Waits (bounded) for a valid word, returns it and lets it be taken on the next edge.
    task automatic get_word(output logic [1:0] ch, output logic signed [23:0] d);
        int n;
        n = 0;
        while (!o_valid && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL get_word_timeout: o_valid=%0b required 1", o_valid);
        end
        ch = o_ch;
        d  = o_data;
        step();
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_cfg_load = 1'b0; i_clr_status = 1'b0; i_dec_log2 = 4'd0; i_data = '0;
        step(); step();
        i_rst = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %0b want 0", o_valid); end
        checks++; if (o_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready: got %0b want 0", o_ready); end
        checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0b want 0", o_overrun); end
        checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %0b want 0", o_cfg_err); end
        checks++; if (o_data !== 24'sd0)  begin errors++; $display("FAIL rst_data: got %0d want 0", o_data); end
        checks++; if (o_ch !== 2'd0)      begin errors++; $display("FAIL rst_ch: got %0d want 0", o_ch); end
        checks++; if (o_dec_log2 !== 4'd6) begin errors++; $display("FAIL rst_dec: got %0d want 6", o_dec_log2); end
    endtask

    task automatic test_config();
        i_enable = 1'b1;
        load_dec(4'd4);
        checks++; if (o_cfg_err !== 1'b1)  begin errors++; $display("FAIL cfg_bad_err: got %0b want 1", o_cfg_err); end
        checks++; if (o_ready !== 1'b0)    begin errors++; $display("FAIL cfg_bad_ready: got %0b want 0", o_ready); end
        checks++; if (o_dec_log2 !== 4'd6) begin errors++; $display("FAIL cfg_bad_dec: got %0d want 6", o_dec_log2); end
        load_dec(4'd7);
        checks++; if (o_cfg_err !== 1'b0)  begin errors++; $display("FAIL cfg_good_err: got %0b want 0", o_cfg_err); end
        checks++; if (o_ready !== 1'b1)    begin errors++; $display("FAIL cfg_good_ready: got %0b want 1", o_ready); end
        checks++; if (o_dec_log2 !== 4'd7) begin errors++; $display("FAIL cfg_good_dec: got %0d want 7", o_dec_log2); end
    endtask

    // dec 32, DC inputs; first frame = x*C(32,4)>>>12, settled = x<<8.
    task automatic test_latency_dc();
        logic [1:0]         ch;
        logic signed [23:0] d;
        bit                 early;
        int                 exp1 [4];
        int                 expss [4];
        exp1  = '{8779, -8780, 8, -9};
        expss = '{256000, -256000, 256, -256};
        set_all(16'sd1000, -16'sd1000, 16'sd1, -16'sd1);
        i_valid = 1'b1;
        i_ready = 1'b1;
        load_dec(4'd5);
        early = 1'b0;
        for (int n = 1; n < 32; n++) begin
            step();
            if (o_valid) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL lat_early: o_valid seen before 32nd accept"); end
        step();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0b want 1", o_valid); end
        checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL lat_busy: got %0b want 1", o_busy); end
        for (int c = 0; c < 4; c++) begin
            get_word(ch, d);
            checks++; if (ch !== 2'(c)) begin errors++; $display("FAIL f1_ch: got %0d want %0d", ch, c); end
            checks++; if (int'(d) !== exp1[c]) begin errors++; $display("FAIL f1_data ch%0d: got %0d want %0d", c, d, exp1[c]); end
            if (c < 3) begin
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid ch%0d: got %0b want 1", c, o_valid); end
            end
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL f1_end_valid: got %0b want 0", o_valid); end
        for (int w = 0; w < 12; w++) get_word(ch, d);
        for (int f = 5; f <= 6; f++) begin
            for (int c = 0; c < 4; c++) begin
                get_word(ch, d);
                checks++; if (ch !== 2'(c)) begin errors++; $display("FAIL dc_ch f%0d: got %0d want %0d", f, ch, c); end
                checks++; if (int'(d) !== expss[c]) begin errors++; $display("FAIL dc_data f%0d ch%0d: got %0d want %0d", f, c, d, expss[c]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]         ch;
        logic signed [23:0] d;
        bit                 stable;
        int                 n;
        int                 expss [4];
        expss = '{256000, -256000, 256, -256};
        i_ready = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            step();
            n++;
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_start: got %0b want 1", o_valid); end
        checks++; if (o_ch !== 2'd0 || o_data !== 24'sd256000) begin
            errors++; $display("FAIL bp_word0: got ch%0d %0d want ch0 256000", o_ch, o_data);
        end
        stable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) begin
                i_cfg_load = 1'b1;
                i_dec_log2 = 4'd7;
            end
            step();
            i_cfg_load = 1'b0;
            if (o_valid !== 1'b1 || o_ch !== 2'd0 || o_data !== 24'sd256000) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1)     begin errors++; $display("FAIL bp_stable: output changed during stall"); end
        checks++; if (o_overrun !== 1'b1)  begin errors++; $display("FAIL bp_overrun: got %0b want 1", o_overrun); end
        checks++; if (o_dec_log2 !== 4'd5) begin errors++; $display("FAIL bp_emit_load: dec got %0d want 5", o_dec_log2); end
        checks++; if (o_cfg_err !== 1'b0)  begin errors++; $display("FAIL bp_emit_err: got %0b want 0", o_cfg_err); end
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            get_word(ch, d);
            checks++; if (ch !== 2'(c) || int'(d) !== expss[c]) begin
                errors++; $display("FAIL bp_drain: got ch%0d %0d want ch%0d %0d", ch, d, c, expss[c]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            get_word(ch, d);
            checks++; if (ch !== 2'(c)) begin errors++; $display("FAIL bp_next_ch: got %0d want %0d", ch, c); end
        end
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %0b want 1", o_overrun); end
        i_clr_status = 1'b1;
        step();
        i_clr_status = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL bp_clear: got %0b want 0", o_overrun); end
    endtask

    // dec 512, all channels at negative full scale; settled = -32768<<8.
    task automatic test_fullscale();
        logic [1:0]         ch;
        logic signed [23:0] d;
        set_all(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        i_ready = 1'b1;
        load_dec(4'd9);
        checks++; if (o_dec_log2 !== 4'd9) begin errors++; $display("FAIL fs_dec: got %0d want 9", o_dec_log2); end
        for (int w = 0; w < 16; w++) get_word(ch, d);
        for (int f = 5; f <= 6; f++) begin
            for (int c = 0; c < 4; c++) begin
                get_word(ch, d);
                checks++; if (ch !== 2'(c) || d !== -24'sd8388608) begin
                    errors++; $display("FAIL fs_data f%0d: got ch%0d %0d want ch%0d -8388608", f, ch, d, c);
                end
            end
        end
    endtask

    // Reset while ch1 is on the output, then a fresh run at the default dec 64.
    task automatic test_reset_mid_emit();
        logic [1:0]         ch;
        logic signed [23:0] d;
        int                 exp1 [4];
        int                 expss [4];
        exp1  = '{9695, -9696, 9, -10};
        expss = '{256000, -256000, 256, -256};
        set_all(16'sd1000, -16'sd1000, 16'sd1, -16'sd1);
        i_ready = 1'b1;
        load_dec(4'd5);
        get_word(ch, d);
        checks++; if (o_valid !== 1'b1 || o_ch !== 2'd1) begin
            errors++; $display("FAIL rme_pre: got valid %0b ch%0d want valid 1 ch1", o_valid, o_ch);
        end
        i_rst = 1'b1;
        step();
        checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL rme_valid: got %0b want 0", o_valid); end
        checks++; if (o_dec_log2 !== 4'd6) begin errors++; $display("FAIL rme_dec: got %0d want 6", o_dec_log2); end
        checks++; if (o_busy !== 1'b0 || o_ch !== 2'd0) begin
            errors++; $display("FAIL rme_state: got busy %0b ch%0d want busy 0 ch0", o_busy, o_ch);
        end
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            get_word(ch, d);
            checks++; if (ch !== 2'(c) || int'(d) !== exp1[c]) begin
                errors++; $display("FAIL rme_f1: got ch%0d %0d want ch%0d %0d", ch, d, c, exp1[c]);
            end
        end
        for (int w = 0; w < 12; w++) get_word(ch, d);
        for (int c = 0; c < 4; c++) begin
            get_word(ch, d);
            checks++; if (ch !== 2'(c) || int'(d) !== expss[c]) begin
                errors++; $display("FAIL rme_f5: got ch%0d %0d want ch%0d %0d", ch, d, c, expss[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_latency_dc();
        test_backpressure();
        test_fullscale();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
